// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Two-master Avalon-MM arbiter for the shared SDRAM port. m0 has
//            priority and m1 has a starvation guard. A pending-read ID FIFO
//            routes returned read beats to the issuing master. Defining
//            SDRAM_ARB_STATS_EN enables the per-master accept counters.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_BYTES   = 4,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [8*DATA_BYTES-1:0] m0_writedata,
    input  logic [DATA_BYTES-1:0]   m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [8*DATA_BYTES-1:0] m0_readdata,
    output logic                    m0_readdatavalid,
    input  logic [ADDR_W-1:0]       m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [8*DATA_BYTES-1:0] m1_writedata,
    input  logic [DATA_BYTES-1:0]   m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [8*DATA_BYTES-1:0] m1_readdata,
    output logic                    m1_readdatavalid,
    output logic [ADDR_W-1:0]       s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [8*DATA_BYTES-1:0] s_writedata,
    output logic [DATA_BYTES-1:0]   s_byteenable,
    input  logic                    s_waitrequest,
    input  logic [8*DATA_BYTES-1:0] s_readdata,
    input  logic                    s_readdatavalid,
    output logic                    err_orphan,
    output logic [31:0]             stat_m0_accepts,
    output logic [31:0]             stat_m1_accepts
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_M0   = 2'd1;
    localparam logic [1:0] GNT_M1   = 2'd2;

    localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(MAX_PENDING);
    localparam logic [SC_W-1:0]  C_STARVE = SC_W'(STARVE_LIMIT);

    logic [1:0]             r_grant;
    logic [SC_W-1:0]        r_starve_cnt;
    logic [SC_W-1:0]        w_starve_nxt;
    logic [MAX_PENDING-1:0] r_ids;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err_orphan;

    logic w_m0_req, w_m1_req;
    logic w_g_read, w_g_write;
    logic w_read_block, w_g_wait, w_accept, w_lock;
    logic w_push, w_pop, w_head;

    assign w_m0_req = m0_read | m0_write;
    assign w_m1_req = m1_read | m1_write;

    always_comb begin
        w_g_read     = 1'b0;
        w_g_write    = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        case (r_grant)
            GNT_M0: begin
                w_g_read     = m0_read;
                w_g_write    = m0_write;
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
            end
            GNT_M1: begin
                w_g_read     = m1_read;
                w_g_write    = m1_write;
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end
            default: ;
        endcase
    end

    // A return beat in the same cycle frees a slot, so a full FIFO only blocks without one.
    assign w_read_block = (r_count == C_FULL) & w_g_read & ~s_readdatavalid;
    assign w_g_wait     = s_waitrequest | w_read_block;
    assign w_accept     = (w_g_read | w_g_write) & ~w_g_wait;
    assign w_lock       = (w_g_read | w_g_write) & w_g_wait;

    assign s_read  = w_g_read & ~w_read_block;
    assign s_write = w_g_write;

    assign m0_waitrequest = (r_grant == GNT_M0) ? w_g_wait : 1'b1;
    assign m1_waitrequest = (r_grant == GNT_M1) ? w_g_wait : 1'b1;

    assign w_push = w_accept & w_g_read;
    assign w_pop  = s_readdatavalid & (r_count != '0);
    assign w_head = r_ids[r_rd_ptr];

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop & w_head;
    assign err_orphan       = r_err_orphan;

    // Post-update count drives arbitration so m0 gets exactly STARVE_LIMIT accepts in a row.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!w_m1_req || (w_accept && r_grant == GNT_M1)) begin
            w_starve_nxt = '0;
        end else if (w_accept && r_grant == GNT_M0 && r_starve_cnt < C_STARVE) begin
            w_starve_nxt = r_starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= GNT_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            if (!w_lock) begin
                if (w_m0_req && (!w_m1_req || w_starve_nxt < C_STARVE)) begin
                    r_grant <= GNT_M0;
                end else if (w_m1_req) begin
                    r_grant <= GNT_M1;
                end else begin
                    r_grant <= GNT_NONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ids        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wr_ptr] <= (r_grant == GNT_M1);
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (s_readdatavalid && r_count == '0) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [31:0] r_stat_m0;
    logic [31:0] r_stat_m1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_m0 <= '0;
            r_stat_m1 <= '0;
        end else if (w_accept) begin
            if (r_grant == GNT_M0 && r_stat_m0 != '1) begin
                r_stat_m0 <= r_stat_m0 + 32'd1;
            end
            if (r_grant == GNT_M1 && r_stat_m1 != '1) begin
                r_stat_m1 <= r_stat_m1 + 32'd1;
            end
        end
    end

    assign stat_m0_accepts = r_stat_m0;
    assign stat_m1_accepts = r_stat_m1;
`else
    assign stat_m0_accepts = '0;
    assign stat_m1_accepts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// Self-checking bench for sdram_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic        err_orphan;
    logic [31:0] stat_m0_accepts, stat_m1_accepts;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan),
        .stat_m0_accepts(stat_m0_accepts), .stat_m1_accepts(stat_m1_accepts)
    );

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (!(m0_read && m0_write)) else $error("illegal m0 read+write");
            assert (!(m1_read && m1_write)) else $error("illegal m1 read+write");
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = 32'h100; m1_address = 32'h200;
        m0_writedata = 32'h1111_0000; m1_writedata = 32'h2222_0000;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        repeat (2) tick();
        rst = 0;
    endtask

    typedef struct {
        bit r0, w0, r1, w1, sw, rdv;
        bit e_rd, e_wr, e_w0, e_w1, e_v0, e_v1;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[10];

    // Behavioural model state for the randomized phase.
    int          owner;
    bit          pq[$];
    int          streak;
    bit          orph;
    bit          gr, gw, blk, gwt, pop, acc, req0, req1, ev0, ev1, ew0, ew1;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    int          acc_cnt;
    bit          a0, a1;

    initial begin
        do_reset();

        // Reset state
        #2;
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_waitreq", {m0_waitrequest, m1_waitrequest}, 2'b11);
        chk("rst_rdvalid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        chk("rst_err_orphan", err_orphan, 0);

        // Vector table: one row per cycle, starting from the reset cycle.
        //          r0 w0 r1 w1 sw rdv  rd wr w0 w1 v0 v1  addr
        vt[0] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 32'h0};
        vt[1] = '{1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 32'h0};
        vt[2] = '{1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 32'h100};
        vt[3] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 32'h100};
        vt[4] = '{0, 0, 0, 1, 1, 0,   0, 1, 1, 1, 0, 0, 32'h200};
        vt[5] = '{1, 0, 0, 1, 1, 0,   0, 1, 1, 1, 0, 0, 32'h200};
        vt[6] = '{1, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 32'h200};
        vt[7] = '{1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 32'h100};
        vt[8] = '{0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0, 32'h100};
        vt[9] = '{0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 1, 0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            m0_read = vt[i].r0; m0_write = vt[i].w0;
            m1_read = vt[i].r1; m1_write = vt[i].w1;
            s_waitrequest = vt[i].sw; s_readdatavalid = vt[i].rdv;
            #2;
            chk($sformatf("vec%0d_ctrl", i),
                {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid},
                {vt[i].e_rd, vt[i].e_wr, vt[i].e_w0, vt[i].e_w1, vt[i].e_v0, vt[i].e_v1});
            chk($sformatf("vec%0d_addr", i), s_address, vt[i].e_addr);
        end

        // Single m0 read, data returned 3 cycles after the accept
        do_reset();
        m0_read = 1;
        #2;
        chk("single_rd_pre", s_read, 0);
        tick(); #2;
        chk("single_rd_fwd", {s_read, m0_waitrequest}, 2'b10);
        chk("single_rd_addr", s_address, 32'h100);
        tick(); m0_read = 0;
        tick();
        tick(); s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
        #2;
        chk("single_rd_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b10);
        chk("single_rd_data", m0_readdata, 32'hDEADBEEF);
        tick(); s_readdatavalid = 0;

        // Both masters saturating: 16 m0 accepts then 1 m1 accept, no bubbles
        do_reset();
        m0_write = 1; m1_write = 1;
        #2;
        for (int c = 1; c <= 52; c++) begin
            tick(); #2;
            a0 = s_write && !m0_waitrequest;
            a1 = s_write && !m1_waitrequest;
            chk($sformatf("starve_acc%0d", c), {a0, a1},
                (((c - 1) % 17) == 16) ? 2'b01 : 2'b10);
        end

        // m1 write stalled 5 cycles while m0 starts requesting
        do_reset();
        m1_write = 1; m1_writedata = 32'hCAFE0001; m1_byteenable = 4'h5; s_waitrequest = 1;
        for (int k = 0; k < 5; k++) begin
            tick(); m0_read = 1; #2;
            chk($sformatf("stall%0d_ctrl", k),
                {s_write, s_read, m0_waitrequest, m1_waitrequest}, 4'b1011);
            chk($sformatf("stall%0d_cmd", k), {s_address, s_writedata},
                {32'h200, 32'hCAFE0001});
            chk($sformatf("stall%0d_be", k), s_byteenable, 4'h5);
        end
        tick(); s_waitrequest = 0; #2;
        chk("stall_release", {s_write, m1_waitrequest, m0_waitrequest}, 3'b101);
        tick(); m1_write = 0; #2;
        chk("stall_then_m0", {s_read, m0_waitrequest}, 2'b10);
        chk("stall_then_m0_addr", s_address, 32'h100);
        tick(); m0_read = 0;

        // Pending FIFO full: 9th read stalls until a return beat frees a slot
        do_reset();
        m0_read = 1; m0_address = 32'h300;
        acc_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick(); #2;
            if (s_read && !m0_waitrequest) acc_cnt++;
        end
        chk("full_accepts", acc_cnt, 8);
        chk("full_blocked", {s_read, m0_waitrequest}, 2'b01);
        tick(); s_readdatavalid = 1; s_readdata = 32'h5A5A; #2;
        chk("full_release", {s_read, m0_waitrequest, m0_readdatavalid}, 3'b101);
        for (int k = 0; k < 8; k++) begin
            tick(); m0_read = 0; s_readdatavalid = 1; #2;
            chk($sformatf("full_drain%0d", k), {m0_readdatavalid, m1_readdatavalid}, 2'b10);
        end
        tick(); s_readdatavalid = 0; #2;
        chk("full_no_orphan", err_orphan, 0);

        // Interleaved reads m0, m1, m0 with returns A, B, C
        do_reset();
        m0_read = 1;
        tick();
        tick(); m0_read = 0; m1_read = 1;
        tick();
        tick(); m1_read = 0; m0_read = 1;
        tick();
        tick(); m0_read = 0; s_readdatavalid = 1; s_readdata = 32'hA; #2;
        chk("ilv_ret_a", {m0_readdatavalid, m1_readdatavalid, m0_readdata}, {2'b10, 32'hA});
        tick(); s_readdata = 32'hB; #2;
        chk("ilv_ret_b", {m0_readdatavalid, m1_readdatavalid, m1_readdata}, {2'b01, 32'hB});
        tick(); s_readdata = 32'hC; #2;
        chk("ilv_ret_c", {m0_readdatavalid, m1_readdatavalid, m0_readdata}, {2'b10, 32'hC});
        tick(); s_readdatavalid = 0;

        // Orphan return is dropped, flag is sticky until reset
        do_reset();
        tick(); s_readdatavalid = 1; s_readdata = 32'h77; #2;
        chk("orphan_dropped", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        tick(); s_readdatavalid = 0; #2;
        chk("orphan_set", err_orphan, 1);
        tick(); tick(); #2;
        chk("orphan_sticky", err_orphan, 1);
        tick(); rst = 1;
        tick(); rst = 0; #2;
        chk("orphan_cleared", err_orphan, 0);

        // Randomized traffic against the behavioural model
        do_reset();
        owner = -1; pq.delete(); streak = 0; orph = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            case ($urandom_range(0, 4))
                1, 3:    begin m0_read = 1; m0_write = 0; end
                2:       begin m0_read = 0; m0_write = 1; end
                default: begin m0_read = 0; m0_write = 0; end
            endcase
            case ($urandom_range(0, 4))
                1, 3:    begin m1_read = 1; m1_write = 0; end
                2:       begin m1_read = 0; m1_write = 1; end
                default: begin m1_read = 0; m1_write = 0; end
            endcase
            m0_address = $urandom; m1_address = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom;
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            s_waitrequest = ($urandom_range(0, 3) == 0);
            s_readdatavalid = (pq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 49) == 0);
            s_readdata = $urandom;
            rst = ($urandom_range(0, 399) == 0);
            #2;

            req0 = m0_read || m0_write;
            req1 = m1_read || m1_write;
            gr = 0; gw = 0; e_addr = 0; e_wd = 0; e_be = 0;
            if (owner == 0) begin
                gr = m0_read; gw = m0_write; e_addr = m0_address; e_wd = m0_writedata; e_be = m0_byteenable;
            end else if (owner == 1) begin
                gr = m1_read; gw = m1_write; e_addr = m1_address; e_wd = m1_writedata; e_be = m1_byteenable;
            end
            pop = s_readdatavalid && pq.size() > 0;
            blk = gr && pq.size() == 8 && !s_readdatavalid;
            gwt = s_waitrequest || blk;
            acc = (gr || gw) && !gwt;
            ew0 = (owner == 0) ? gwt : 1'b1;
            ew1 = (owner == 1) ? gwt : 1'b1;
            ev0 = pop && pq[0] == 0;
            ev1 = pop && pq[0] == 1;

            chk("rnd_ctrl",
                {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_orphan},
                {gr && !blk, gw, ew0, ew1, ev0, ev1, orph});
            chk("rnd_addr", s_address, e_addr);
            chk("rnd_wdata", s_writedata, e_wd);
            chk("rnd_be", s_byteenable, e_be);
            chk("rnd_rdata", {m0_readdata, m1_readdata}, {s_readdata, s_readdata});

            if (rst) begin
                owner = -1; pq.delete(); streak = 0; orph = 0;
            end else begin
                if (s_readdatavalid && pq.size() == 0) orph = 1;
                if (pop) void'(pq.pop_front());
                if (acc && gr) pq.push_back(owner == 1);
                if (!req1 || (acc && owner == 1)) streak = 0;
                else if (acc && owner == 0 && streak < 16) streak++;
                if (!((gr || gw) && gwt)) begin
                    if (req0 && (!req1 || streak < 16)) owner = 0;
                    else if (req1) owner = 1;
                    else owner = -1;
                end
            end
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
